// File: rtl/bg_line_fetcher_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bg_line_fetcher_pkg                                           |
// | Brief    : Shared types and constants for the background line fetcher.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package bg_line_fetcher_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MAP  = 3'd1,
        S_TLO  = 3'd2,
        S_THI  = 3'd3,
        S_PUSH = 3'd4,
        S_DONE = 3'd5
    } state_t;

    typedef struct packed {
        logic [7:0] lcd_control;
        logic [7:0] scroll_y;
        logic [7:0] scroll_x;
        logic [7:0] bg_palette;
    } control_reg_t;

    localparam logic [12:0] MAP_BASE_0       = 13'h1800;
    localparam logic [12:0] MAP_BASE_1       = 13'h1C00;
    localparam logic [12:0] TILE_BASE_SIGNED = 13'h1000;
    localparam int          LINE_W           = 160;

endpackage
`default_nettype wire

// File: rtl/bg_line_fetcher_pixel_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bg_pixel_shifter                                              |
// | Brief    : Holds one tile row (lo/hi planes), shifts MSB first, maps     |
// |            the colour index through the background palette.             |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module bg_pixel_shifter (
    input  logic       clk_hdmi,
    input  logic       rst,
    input  logic       load_lo,
    input  logic       load_hi,
    input  logic       shift,
    input  logic [7:0] plane_data,
    input  logic [7:0] palette,
    output logic [1:0] ci,
    output logic [1:0] shade
);
    logic [7:0] lo_q, lo_d;
    logic [7:0] hi_q, hi_d;
    logic [7:0] hi_cur;

    always_comb begin
        // The high plane arrives on the first pixel cycle, so bypass it straight in.
        hi_cur = load_hi ? plane_data : hi_q;
        lo_d   = lo_q;
        hi_d   = hi_q;
        if (load_hi) begin
            hi_d = plane_data;
        end
        if (shift) begin
            lo_d = {lo_q[6:0], 1'b0};
            hi_d = {hi_cur[6:0], 1'b0};
        end
        if (load_lo) begin
            lo_d = plane_data;
        end
        ci    = {hi_cur[7], lo_q[7]};
        shade = palette[{ci, 1'b0} +: 2];
    end

    always_ff @(posedge clk_hdmi or negedge rst) begin
        if (!rst) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bg_line_fetcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bg_line_fetcher                                               |
// | Brief    : Fetches background tiles from VRAM for one line and writes   |
// |            palette-mapped pixels into the line buffer.                  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module bg_line_fetcher #(
    parameter int LINE_W        = bg_line_fetcher_pkg::LINE_W,
    parameter int LAST_VIS_LINE = 143
) (
    input  logic                             clk_hdmi,
    input  logic                             rst,
    input  logic                             start,
    input  logic [7:0]                       line,
    input  bg_line_fetcher_pkg::control_reg_t control,
    output logic [12:0]                      rd_address,
    output logic                             oe_vram,
    input  logic [7:0]                       read_data,
    output logic                             px_we,
    output logic [7:0]                       px_addr,
    output logic [1:0]                       px_data,
    output logic                             busy,
    output logic                             done
);
    import bg_line_fetcher_pkg::*;

    localparam logic [7:0] LAST_COL  = 8'(LINE_W - 1);
    localparam logic [7:0] LAST_LINE = 8'(LAST_VIS_LINE);

    state_t      state_q, state_d;
    logic [7:0]  line_q, line_d;
    logic [7:0]  scx_q, scx_d;
    logic [7:0]  scy_q, scy_d;
    logic [7:0]  bgp_q, bgp_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  col_q, col_d;
    logic [4:0]  tile_q, tile_d;
    logic [2:0]  slot_q, slot_d;
    logic [12:0] addr_q, addr_d;
    logic        unsigned_q, unsigned_d;
    logic        map_sel_q, map_sel_d;
    logic        bg_en_q, bg_en_d;

    logic [7:0]  ybg;
    logic [4:0]  map_col;
    logic [12:0] map_addr;
    logic [7:0]  tile_idx;
    logic [12:0] tbase;
    logic [12:0] row_addr;
    logic        keep;
    logic        load_lo, load_hi, shift;
    logic [1:0]  px_ci, shade;
    logic        unused_ctrl;

    assign unused_ctrl = ^{control.lcd_control[6:5], control.lcd_control[2:1], px_ci};

    assign ybg      = line_q + scy_q;
    assign map_col  = scx_q[7:3] + tile_q;
    assign map_addr = (map_sel_q ? MAP_BASE_1 : MAP_BASE_0)
                    + {3'b000, ybg[7:3], 5'b00000} + {8'h00, map_col};
    // The tile index is on read_data during TLO and only registered afterwards.
    assign tile_idx = (state_q == S_TLO) ? read_data : idx_q;
    assign tbase    = unsigned_q ? {1'b0, tile_idx, 4'b0000}
                                 : TILE_BASE_SIGNED + {tile_idx[7], tile_idx, 4'b0000};
    assign row_addr = tbase + {9'b0, ybg[2:0], 1'b0};
    assign keep     = !bg_en_q || !((tile_q == 5'd0) && (slot_q < scx_q[2:0]));

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        scx_d      = scx_q;
        scy_d      = scy_q;
        bgp_d      = bgp_q;
        idx_d      = idx_q;
        col_d      = col_q;
        tile_d     = tile_q;
        slot_d     = slot_q;
        addr_d     = addr_q;
        unsigned_d = unsigned_q;
        map_sel_d  = map_sel_q;
        bg_en_d    = bg_en_q;
        oe_vram    = 1'b0;
        px_we      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        load_lo    = 1'b0;
        load_hi    = 1'b0;
        shift      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && (line <= LAST_LINE) && control.lcd_control[7]) begin
                    line_d     = line;
                    scx_d      = control.scroll_x;
                    scy_d      = control.scroll_y;
                    bgp_d      = control.bg_palette;
                    unsigned_d = control.lcd_control[4];
                    map_sel_d  = control.lcd_control[3];
                    bg_en_d    = control.lcd_control[0];
                    tile_d     = '0;
                    slot_d     = '0;
                    col_d      = '0;
                    state_d    = S_MAP;
                end
            end
            S_MAP: begin
                busy = 1'b1;
                if (bg_en_q) begin
                    oe_vram = 1'b1;
                    addr_d  = map_addr;
                    state_d = S_TLO;
                end else begin
                    state_d = S_PUSH;
                end
            end
            S_TLO: begin
                busy    = 1'b1;
                oe_vram = 1'b1;
                idx_d   = read_data;
                addr_d  = row_addr;
                state_d = S_THI;
            end
            S_THI: begin
                busy    = 1'b1;
                oe_vram = 1'b1;
                load_lo = 1'b1;
                addr_d  = {row_addr[12:1], 1'b1};
                state_d = S_PUSH;
            end
            S_PUSH: begin
                busy    = 1'b1;
                px_we   = keep;
                load_hi = bg_en_q && (slot_q == 3'd0);
                shift   = bg_en_q;
                slot_d  = slot_q + 3'd1;
                if (px_we && (col_q != LAST_COL)) begin
                    col_d = col_q + 8'd1;
                end
                if (px_we && (col_q == LAST_COL)) begin
                    state_d = S_DONE;
                end else if (bg_en_q && (slot_q == 3'd7)) begin
                    tile_d  = tile_q + 5'd1;
                    state_d = S_MAP;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (busy && !control.lcd_control[7]) begin
            state_d = S_IDLE;
        end
    end

    assign rd_address = addr_d;
    assign px_addr    = col_q;
    assign px_data    = ((state_q == S_PUSH) && bg_en_q) ? shade : 2'b00;

    bg_pixel_shifter u_shifter (
        .clk_hdmi   (clk_hdmi),
        .rst        (rst),
        .load_lo    (load_lo),
        .load_hi    (load_hi),
        .shift      (shift),
        .plane_data (read_data),
        .palette    (bgp_q),
        .ci         (px_ci),
        .shade      (shade)
    );

    always_ff @(posedge clk_hdmi or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            line_q     <= '0;
            scx_q      <= '0;
            scy_q      <= '0;
            bgp_q      <= '0;
            idx_q      <= '0;
            col_q      <= '0;
            tile_q     <= '0;
            slot_q     <= '0;
            addr_q     <= '0;
            unsigned_q <= 1'b0;
            map_sel_q  <= 1'b0;
            bg_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            scx_q      <= scx_d;
            scy_q      <= scy_d;
            bgp_q      <= bgp_d;
            idx_q      <= idx_d;
            col_q      <= col_d;
            tile_q     <= tile_d;
            slot_q     <= slot_d;
            addr_q     <= addr_d;
            unsigned_q <= unsigned_d;
            map_sel_q  <= map_sel_d;
            bg_en_q    <= bg_en_d;
        end
    end

endmodule
`default_nettype wire
